// File: rtl/free_list_if.sv
// Tag type and the dispatch/retire/squash bundle between the rename stage and the free list.
// The master side is rename/ROB; the slave side is the free list itself.
package free_list_pkg;
    parameter int unsigned FL_NUM_PHYS = 64;
    parameter int unsigned PHYS_W      = $clog2(FL_NUM_PHYS);

    typedef struct packed {
        logic [PHYS_W-1:0] phys_reg;
    } tag_t;
endpackage

interface free_list_if #(
    parameter int unsigned NUM_FREE = 32
);
    import free_list_pkg::*;

    logic                          dispatch_en;
    tag_t                          alloc_t;
    logic                          alloc_valid;
    logic                          retire_en;
    tag_t                          retire_t_old;
    logic                          squash_en;
    logic [$clog2(NUM_FREE+1)-1:0] free_count;

    modport master (
        output dispatch_en, retire_en, retire_t_old, squash_en,
        input  alloc_t, alloc_valid, free_count
    );

    modport slave (
        input  dispatch_en, retire_en, retire_t_old, squash_en,
        output alloc_t, alloc_valid, free_count
    );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical tags: pops at dispatch, pushes T_old at retire,
// and on squash rewinds head to the tail so every in-flight tag becomes free again.
module free_list
    import free_list_pkg::*;
#(
    parameter  int unsigned NUM_PHYS = FL_NUM_PHYS,
    parameter  int unsigned NUM_ARCH = 32,
    localparam int unsigned NUM_FREE = NUM_PHYS - NUM_ARCH,
    localparam int unsigned PTR_W    = $clog2(NUM_FREE),
    localparam int unsigned CNT_W    = $clog2(NUM_FREE + 1)
) (
    input logic        clock,
    input logic        reset,
    free_list_if.slave fl
);

    logic [PHYS_W-1:0] buffer_q [NUM_FREE];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic alloc_valid;
    logic full;
    logic pop;
    logic push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_FREE - 1)) ? '0 : p + 1'b1;
    endfunction

    assign alloc_valid = (count_q != '0);
    assign full        = (count_q == CNT_W'(NUM_FREE));

    // A retire against a full list has nowhere to go; it is dropped and flagged below.
    assign pop  = fl.dispatch_en && alloc_valid && !fl.squash_en;
    assign push = fl.retire_en && !full;

    always_comb begin
        tail_d  = tail_q;
        head_d  = head_q;
        count_d = count_q;

        if (push) begin
            tail_d = ptr_inc(tail_q);
        end

        // buffer[tail..head-1] still holds the in-flight tags, so moving head back to
        // the post-retire tail returns all of them in one cycle.
        if (fl.squash_en) begin
            head_d  = tail_d;
            count_d = CNT_W'(NUM_FREE);
        end else begin
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            count_d = count_q - CNT_W'(pop) + CNT_W'(push);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(NUM_FREE);
            for (int i = 0; i < int'(NUM_FREE); i++) begin
                buffer_q[i] <= PHYS_W'(int'(NUM_ARCH) + i);
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                buffer_q[tail_q] <= fl.retire_t_old.phys_reg;
            end
        end
    end

    // The offer reads the current head; a same-cycle push lands only at the next edge.
    assign fl.alloc_valid      = alloc_valid;
    assign fl.alloc_t.phys_reg = buffer_q[head_q];
    assign fl.free_count       = count_q;

    retire_on_full_a : assert property (@(posedge clock) disable iff (reset)
        !(fl.retire_en && full));

endmodule
